// File: rtl/minitb_ahb_pkg.sv
// Shared AHB-lite types for the miniTB slave memory and master BFM.
package minitb_ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [1:0] {
        ADDR,
        WAIT,
        ERR1,
        ERR2
    } slave_state_t;

    // Width of the wait-state counter (waitStates range 0..15).
    localparam int unsigned WAIT_CNT_W = 4;

    // Index width for a memory of n words; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/minitb_ahb_slave_ram.sv
// Word array with one synchronous write port and one registered read port.
// A read issued on the same edge as a write to the same index returns the
// new write data; an out-of-range read (hit=0) loads zero.
module minitb_ahb_slave_ram
    import minitb_ahb_pkg::*;
#(
    parameter int unsigned dataWidth = 32,
    parameter int unsigned depth     = 16,
    parameter int unsigned idxWidth  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [idxWidth-1:0]  wr_idx,
    input  logic [dataWidth-1:0] wr_data,
    input  logic                 rd_en,
    input  logic                 rd_hit,
    input  logic [idxWidth-1:0]  rd_idx,
    output logic [dataWidth-1:0] rd_data
);

    // Contents survive reset; they only start from zero.
    logic [dataWidth-1:0] mem [depth] = '{default: '0};

    // Write port: commits at the end of a completing write data phase.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read port: captured on address accept, held until the next read accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (!rd_hit) begin
                rd_data <= '0;
            end else if (wr_en && (wr_idx == rd_idx)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/minitb_ahb_slave_mem.sv
// AHB-lite slave memory: registers the address phase, completes the data
// phase after waitStates stall cycles, and answers out-of-range addresses
// with a two-cycle ERROR response.
module minitb_ahb_slave_mem
    import minitb_ahb_pkg::*;
#(
    parameter int unsigned addrWidth  = 8,
    parameter int unsigned dataWidth  = 32,
    parameter int unsigned depth      = 16,
    parameter int unsigned waitStates = 0
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 hsel,
    input  logic [1:0]           htrans,
    input  logic [addrWidth-1:0] haddr,
    input  logic                 hwrite,
    input  logic [dataWidth-1:0] hwdata,
    output logic [dataWidth-1:0] hrdata,
    output logic                 hready,
    output logic [1:0]           hresp
);

    localparam int unsigned           IDX_W     = idx_width(depth);
    localparam logic [addrWidth:0]    DEPTH_LIM = (addrWidth + 1)'(depth);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(waitStates);

    slave_state_t          state_q;
    slave_state_t          state_d;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    logic [IDX_W-1:0] addr_q;
    logic             write_q;
    logic             inrange_q;
    logic             pending_q;

    logic             is_xfer;
    logic             accept;
    logic             in_range;
    logic             commit;
    logic [IDX_W-1:0] idx;

    assign is_xfer  = htrans_t'(htrans) inside {NONSEQ, SEQ};
    assign accept   = hready && hsel && is_xfer;
    assign in_range = ({1'b0, haddr} < DEPTH_LIM);
    assign idx      = haddr[IDX_W-1:0];
    assign commit   = hready && pending_q && write_q && inrange_q && !hreset;

    // Bus response decoded from the registered state only.
    always_comb begin
        hready = 1'b1;
        hresp  = OKAY;
        case (state_q)
            WAIT: begin
                hready = 1'b0;
            end
            ERR1: begin
                hready = 1'b0;
                hresp  = ERROR;
            end
            ERR2: begin
                hresp  = ERROR;
            end
            default: begin
            end
        endcase
    end

    // Next-state and wait counter; ERR2 may accept a new address like ADDR.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ADDR, ERR2: begin
                state_d = ADDR;
                if (accept) begin
                    if (!in_range) begin
                        state_d = ERR1;
                    end else if (WAIT_INIT != '0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - WAIT_CNT_W'(1);
                if (cnt_q <= WAIT_CNT_W'(1)) begin
                    state_d = ADDR;
                end
            end
            ERR1: begin
                state_d = ERR2;
            end
            default: begin
                state_d = ADDR;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= ADDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Address-phase capture; a data phase is pending until an hready-high edge.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            inrange_q <= 1'b0;
        end else if (hready) begin
            pending_q <= accept;
            if (accept) begin
                addr_q    <= idx;
                write_q   <= hwrite;
                inrange_q <= in_range;
            end
        end
    end

    minitb_ahb_slave_ram #(
        .dataWidth (dataWidth),
        .depth     (depth),
        .idxWidth  (IDX_W)
    ) u_ram (
        .clk     (hclk),
        .rst     (hreset),
        .wr_en   (commit),
        .wr_idx  (addr_q),
        .wr_data (hwdata),
        .rd_en   (accept && !hwrite),
        .rd_hit  (in_range),
        .rd_idx  (idx),
        .rd_data (hrdata)
    );

endmodule

// File: tb/tb_minitb_ahb_slave_mem.sv
// Bench for minitb_ahb_slave_mem: three slaves (0, 2 and 3 wait states) share
// one bus with per-slave hsel; a pipelined master issues transfers and a
// negedge monitor checks each completing data phase against a queue.
module tb_minitb_ahb_slave_mem;

    typedef struct {
        int          d;
        logic        wr;
        logic [7:0]  a;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [1:0]  exp_rsp;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [7:0]  a;
        logic [31:0] rd;
        logic [1:0]  rsp;
    } exp_t;

    logic        clk = 1'b0;
    logic        hreset;
    logic [2:0]  hsel;
    logic [1:0]  htrans;
    logic [7:0]  haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        rdy [3];
    logic [1:0]  rsp [3];
    logic [31:0] rd  [3];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cur      = 0;
    int   low0     = 0;
    logic dp_active = 1'b0;
    exp_t exp_q [$];
    vec_t tbl [18];

    always #5 clk = ~clk;

    minitb_ahb_slave_mem #(.addrWidth(8), .dataWidth(32), .depth(16), .waitStates(0)) u_ws0 (
        .hclk(clk), .hreset(hreset), .hsel(hsel[0]), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hwdata(hwdata), .hrdata(rd[0]), .hready(rdy[0]), .hresp(rsp[0]));

    minitb_ahb_slave_mem #(.addrWidth(8), .dataWidth(32), .depth(16), .waitStates(2)) u_ws2 (
        .hclk(clk), .hreset(hreset), .hsel(hsel[1]), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hwdata(hwdata), .hrdata(rd[1]), .hready(rdy[1]), .hresp(rsp[1]));

    minitb_ahb_slave_mem #(.addrWidth(8), .dataWidth(32), .depth(16), .waitStates(3)) u_ws3 (
        .hclk(clk), .hreset(hreset), .hsel(hsel[2]), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hwdata(hwdata), .hrdata(rd[2]), .hready(rdy[2]), .hresp(rsp[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one address phase to slave d and return just after it is accepted;
    // the transfer's write data is then driven for its data phase.
    task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [31:0] data,
                        input logic [31:0] exp_rd, input logic [1:0] exp_rsp);
        int   n;
        logic ok;
        exp_t e;
        cur     = d;
        hsel    = 3'b000;
        hsel[d] = 1'b1;
        htrans  = 2'b10;
        haddr   = a;
        hwrite  = wr;
        e.wr  = wr;
        e.a   = a;
        e.rd  = exp_rd;
        e.rsp = exp_rsp;
        exp_q.push_back(e);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = rdy[d];
            n++;
        end
        if (!ok) begin
            chk($sformatf("accept_timeout_a%0d", a), 32'(ok), 32'd1);
            void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
        hwdata = data;
    endtask

    // Park the bus and wait until every outstanding data phase has completed.
    task automatic idle_bus();
        int n;
        htrans = 2'b00;
        hsel   = 3'b000;
        hwrite = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a data phase completes in a cycle where the selected slave shows hready=1.
    always @(negedge clk) begin
        exp_t e;
        if (hreset) begin
            dp_active <= 1'b0;
        end else begin
            if (dp_active && rdy[cur]) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("hresp_a%0d", e.a), 32'(rsp[cur]), 32'(e.rsp));
                    if (!e.wr) begin
                        chk($sformatf("hrdata_a%0d", e.a), rd[cur], e.rd);
                    end
                end
            end
            if (cur == 0 && !rdy[0]) begin
                low0 <= low0 + 1;
            end
            if (rdy[cur]) begin
                dp_active <= hsel[cur] && htrans[1];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        //          d  wr    addr    wdata          exp rdata      resp
        tbl[0]  = '{0, 1'b1, 8'd3,  32'hDEADBEEF, 32'h0,         2'b00};
        tbl[1]  = '{0, 1'b0, 8'd3,  32'h0,        32'hDEADBEEF,  2'b00};
        tbl[2]  = '{0, 1'b1, 8'd5,  32'h12345678, 32'h0,         2'b00};
        tbl[3]  = '{0, 1'b0, 8'd5,  32'h0,        32'h12345678,  2'b00};
        tbl[4]  = '{0, 1'b1, 8'd4,  32'h04040404, 32'h0,         2'b00};
        tbl[5]  = '{0, 1'b1, 8'd15, 32'hCAFEF00D, 32'h0,         2'b00};
        tbl[6]  = '{0, 1'b0, 8'd15, 32'h0,        32'hCAFEF00D,  2'b00};
        tbl[7]  = '{0, 1'b1, 8'd20, 32'hFFFFFFFF, 32'h0,         2'b01};
        tbl[8]  = '{0, 1'b0, 8'd4,  32'h0,        32'h04040404,  2'b00};
        tbl[9]  = '{0, 1'b0, 8'd3,  32'h0,        32'hDEADBEEF,  2'b00};
        tbl[10] = '{0, 1'b0, 8'd20, 32'h0,        32'h0,         2'b01};
        tbl[11] = '{0, 1'b1, 8'd16, 32'h11111111, 32'h0,         2'b01};
        tbl[12] = '{0, 1'b0, 8'd0,  32'h0,        32'h0,         2'b00};
        tbl[13] = '{0, 1'b0, 8'd4,  32'h0,        32'h04040404,  2'b00};
        tbl[14] = '{1, 1'b1, 8'd0,  32'hA5A5A5A5, 32'h0,         2'b00};
        tbl[15] = '{1, 1'b1, 8'd4,  32'h44444444, 32'h0,         2'b00};
        tbl[16] = '{1, 1'b0, 8'd0,  32'h0,        32'hA5A5A5A5,  2'b00};
        tbl[17] = '{1, 1'b0, 8'd4,  32'h0,        32'h44444444,  2'b00};

        // Reset held for two edges while the bus requests a NONSEQ read.
        hreset = 1'b1;
        hsel   = 3'b111;
        htrans = 2'b10;
        haddr  = 8'd3;
        hwrite = 1'b0;
        hwdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst1_hready_%0d", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("rst1_hresp_%0d", i), 32'(rsp[i]), 32'd0);
            chk($sformatf("rst1_hrdata_%0d", i), rd[i], 32'd0);
        end
        @(posedge clk);
        #1;
        hreset = 1'b0;
        hsel   = 3'b000;
        htrans = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst2_hready_%0d", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("rst2_hresp_%0d", i), 32'(rsp[i]), 32'd0);
            chk($sformatf("rst2_hrdata_%0d", i), rd[i], 32'd0);
        end
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("idle_hready_%0d", i), 32'(rdy[i]), 32'd1);
            end
        end
        @(posedge clk);
        #1;

        // Pipelined table; the first seven transfers must never stall slave 0.
        low0 = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 7) begin
                idle_bus();
                chk("ws0_hready_low_cycles", 32'(low0), 32'd0);
            end
            if (i > 0 && tbl[i].d != tbl[i-1].d) begin
                idle_bus();
            end
            xfer(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].data, tbl[i].exp_rd, tbl[i].exp_rsp);
        end
        idle_bus();

        // Two wait states: hready low for exactly two cycles, then data.
        xfer(1, 1'b0, 8'd0, 32'h0, 32'hA5A5A5A5, 2'b00);
        htrans = 2'b00;
        hsel   = 3'b000;
        cnt    = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rdy[1]) break;
            cnt++;
        end
        chk("ws2_wait_cycles", 32'(cnt), 32'd2);
        chk("ws2_hrdata", rd[1], 32'hA5A5A5A5);
        chk("ws2_hresp", 32'(rsp[1]), 32'd0);
        @(posedge clk);
        #1;

        // Out-of-range write: ERR1 then ERR2, memory untouched.
        xfer(1, 1'b1, 8'd20, 32'hFFFFFFFF, 32'h0, 2'b01);
        htrans = 2'b00;
        hsel   = 3'b000;
        @(negedge clk);
        chk("err1_hready", 32'(rdy[1]), 32'd0);
        chk("err1_hresp", 32'(rsp[1]), 32'd1);
        @(negedge clk);
        chk("err2_hready", 32'(rdy[1]), 32'd1);
        chk("err2_hresp", 32'(rsp[1]), 32'd1);
        @(posedge clk);
        #1;
        xfer(1, 1'b0, 8'd4, 32'h0, 32'h44444444, 2'b00);
        idle_bus();

        // Reset during the wait states of a write: the write is discarded.
        xfer(2, 1'b1, 8'd7, 32'h0BADF00D, 32'h0, 2'b00);
        htrans = 2'b00;
        hsel   = 3'b000;
        @(negedge clk);
        chk("ws3_in_wait", 32'(rdy[2]), 32'd0);
        @(posedge clk);
        #1;
        hreset = 1'b1;
        @(posedge clk);
        #1;
        hreset = 1'b0;
        @(negedge clk);
        chk("midrst_hready", 32'(rdy[2]), 32'd1);
        chk("midrst_hresp", 32'(rsp[2]), 32'd0);
        chk("midrst_hrdata", rd[2], 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        xfer(2, 1'b0, 8'd7, 32'h0, 32'h0, 2'b00);
        idle_bus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
